signal_scan_ctrl: RTL and testbench

Time-multiplexed activity scanner for a bank of input lines. It shares one window counter and one edge detector between `N_CH` channels, in round-robin order. For each channel it decides "active" (at least one edge in the window) or "idle". It keeps a per-channel status vector and emits a change event, with valid/ready backpressure, whenever a channel's status flips. It sits between the raw external signal pins and the status/interrupt register block, and replaces one dedicated indicator counter per line.

---
 rtl/signal_scan_ctrl_pkg.sv | 18 +
 rtl/signal_scan_ctrl_if.sv | 33 +++
 rtl/signal_scan_ctrl_bit_sync.sv | 34 +++
 rtl/signal_scan_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_signal_scan_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/signal_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// signal_scan_pkg
// Shared types and constants for the signal_scan_ctrl activity scanner.
//   scan_state_t : scanner FSM states
//   SYNC_STAGES  : depth of the input metastability synchronizer
// ---------------------------------------------------------------------------
package signal_scan_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WINDOW   = 2'd1,
    UPDATE   = 2'd2,
    WAIT_EVT = 2'd3
  } scan_state_t;

endpackage

// File: rtl/signal_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// signal_scan_ctrl_if
// Change-event channel from the scanner to the status/interrupt block.
//   evt_valid : event pending (master -> slave)
//   evt_ready : consumer accepts the event (slave -> master)
//   evt_chan  : channel whose status flipped (master -> slave)
//   evt_state : new status of that channel (master -> slave)
// ---------------------------------------------------------------------------
interface signal_scan_ctrl_if #(
  parameter int N_CH = 8
);
  localparam int CH_W = $clog2(N_CH);

  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_chan;
  logic            evt_state;

  modport master (
    output evt_valid,
    output evt_chan,
    output evt_state,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_chan,
    input  evt_state,
    output evt_ready
  );

endinterface

// File: rtl/signal_scan_ctrl_bit_sync.sv
// ---------------------------------------------------------------------------
// bit_sync
// Parameterized-width multi-flop synchronizer for asynchronous inputs.
// Each bit is sampled independently; there is no cross-bit coherence.
//   clk    : destination clock
//   resetn : asynchronous active-low clear of all stages
//   d      : asynchronous input bits
//   q      : synchronized bits (SYNC_STAGES cycles of latency)
// ---------------------------------------------------------------------------
module bit_sync
  import signal_scan_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Stage 0 is the metastable capture flop; the last stage feeds q.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/signal_scan_ctrl.sv
// ---------------------------------------------------------------------------
// signal_scan_ctrl
// Time-multiplexed activity scanner. One window counter and one edge
// detector are shared round-robin across N_CH input lines; each channel is
// judged active (at least one edge in its window) or idle, and every status
// flip is reported as a single-entry valid/ready change event.
//
// Ports:
//   clk       : system clock, rising edge
//   resetn    : asynchronous active-low reset
//   in        : asynchronous signal lines [N_CH]
//   enable    : scan enable, honoured at channel boundaries
//   status    : per-channel activity result (1 = active)
//   scan_done : one-cycle pulse when a full pass completes
//   busy      : FSM not in IDLE
//   evt       : change-event channel (master side)
// ---------------------------------------------------------------------------
module signal_scan_ctrl
  import signal_scan_pkg::*;
#(
  parameter  int N_CH     = 8,
  parameter  int C_WINDOW = 10_000,
  localparam int CNT_W    = $clog2(C_WINDOW),
  localparam int CH_W     = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [N_CH-1:0]     in,
  input  logic                enable,
  output logic [N_CH-1:0]     status,
  output logic                scan_done,
  output logic                busy,
  signal_scan_ctrl_if.master  evt
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(C_WINDOW - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);

  // -------------------------------------------------------------------------
  // Input conditioning: free-running synchronizer plus one delay flop so the
  // edge detector compares two already-synchronized samples.
  // -------------------------------------------------------------------------
  logic [N_CH-1:0] s2;
  logic [N_CH-1:0] s3_q;
  logic [N_CH-1:0] edge_vec;

  bit_sync #(
    .WIDTH (N_CH)
  ) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (in),
    .q      (s2)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s3_q <= '0;
    end else begin
      s3_q <= s2;
    end
  end

  assign edge_vec = s2 ^ s3_q;

  // -------------------------------------------------------------------------
  // Scanner state
  // -------------------------------------------------------------------------
  scan_state_t     state_q,      state_d;
  logic [CH_W-1:0] sel_q,        sel_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic            act_q,        act_d;
  logic [N_CH-1:0] status_q,     status_d;
  logic            evt_valid_q,  evt_valid_d;
  logic [CH_W-1:0] evt_chan_q,   evt_chan_d;
  logic            evt_state_q,  evt_state_d;
  logic            scan_done_q,  scan_done_d;

  logic            advance;
  logic            load_evt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      act_q       <= 1'b0;
      status_q    <= '0;
      evt_valid_q <= 1'b0;
      evt_chan_q  <= '0;
      evt_state_q <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      status_q    <= status_d;
      evt_valid_q <= evt_valid_d;
      evt_chan_q  <= evt_chan_d;
      evt_state_q <= evt_state_d;
      scan_done_q <= scan_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    act_d       = act_q;
    status_d    = status_q;
    evt_valid_d = evt_valid_q;
    evt_chan_d  = evt_chan_q;
    evt_state_d = evt_state_q;
    scan_done_d = 1'b0;
    advance     = 1'b0;
    load_evt    = 1'b0;

    // A pending event is consumed on ready; a new load below overrides this.
    if (evt_valid_q && evt.evt_ready) begin
      evt_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        sel_d = '0;
        if (enable) begin
          cnt_d   = CNT_LOAD;
          act_d   = 1'b0;
          state_d = WINDOW;
        end
      end

      WINDOW: begin
        if (edge_vec[sel_q]) begin
          act_d = 1'b1;
        end
        if (cnt_q == '0) begin
          state_d = UPDATE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      UPDATE: begin
        status_d[sel_q] = act_q;
        if (act_q != status_q[sel_q]) begin
          // Single-entry queue: load only if the slot is free or freeing now.
          if (!evt_valid_q || evt.evt_ready) begin
            load_evt = 1'b1;
            advance  = 1'b1;
          end else begin
            state_d = WAIT_EVT;
          end
        end else begin
          advance = 1'b1;
        end
      end

      WAIT_EVT: begin
        // act_q still holds the result of the stalled channel.
        if (evt.evt_ready) begin
          load_evt = 1'b1;
          advance  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_evt) begin
      evt_valid_d = 1'b1;
      evt_chan_d  = sel_q;
      evt_state_d = act_q;
    end

    // Channel boundary: the only point where enable is re-evaluated.
    if (advance) begin
      scan_done_d = (sel_q == LAST_CH);
      sel_d       = (sel_q == LAST_CH) ? '0 : sel_q + 1'b1;
      if (enable) begin
        cnt_d   = CNT_LOAD;
        act_d   = 1'b0;
        state_d = WINDOW;
      end else begin
        sel_d   = '0;
        state_d = IDLE;
      end
    end
  end

  assign status        = status_q;
  assign scan_done     = scan_done_q;
  assign busy          = (state_q != IDLE);
  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_chan  = evt_chan_q;
  assign evt.evt_state = evt_state_q;

endmodule

// File: tb/tb_signal_scan_ctrl.sv
module tb_signal_scan_ctrl;
  import signal_scan_pkg::*;

  localparam int N_CH     = 4;
  localparam int C_WINDOW = 8;
  localparam int CH_W     = 2;

  typedef struct packed {
    logic [CH_W-1:0] chan;
    logic            state;
  } evt_t;

  logic            clk    = 1'b0;
  logic            resetn = 1'b0;
  logic [N_CH-1:0] in_v   = '0;
  logic            enable = 1'b0;
  logic [N_CH-1:0] status;
  logic            scan_done;
  logic            busy;

  signal_scan_ctrl_if #(.N_CH(N_CH)) evt_if ();

  signal_scan_ctrl #(
    .N_CH     (N_CH),
    .C_WINDOW (C_WINDOW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in        (in_v),
    .enable    (enable),
    .status    (status),
    .scan_done (scan_done),
    .busy      (busy),
    .evt       (evt_if.master)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_evt    = 0;
  evt_t exp_q[$];

  logic [N_CH-1:0] tog_fast = '0;  // lines flipped every cycle
  logic            tog2     = 1'b0; // in[2] flipped every 3 cycles

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    forever begin
      @(negedge clk);
      cycles++;
      if (scan_done) return;
      if (cycles >= limit) begin
        n_checks++;
        n_errors++;
        $display("FAIL scan_done_timeout: no scan_done within %0d cycles", limit);
        return;
      end
    end
  endtask

  task automatic wait_busy(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (busy) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL busy_timeout: busy not seen within %0d cycles", limit);
  endtask

  task automatic wait_wait_evt(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (dut.state_q == WAIT_EVT) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL wait_evt_timeout: WAIT_EVT not reached within %0d cycles", limit);
  endtask

  // Input line generator
  initial begin
    logic [N_CH-1:0] flip;
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      ph++;
      flip = tog_fast;
      if (tog2 && (ph % 3 == 0)) flip[2] = 1'b1;
      in_v = in_v ^ flip;
    end
  end

  // Event monitor / scoreboard
  initial begin
    logic hold;
    evt_t held;
    evt_t got;
    evt_t e;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #1;
      got = {evt_if.evt_chan, evt_if.evt_state};
      if (!resetn) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("evt_hold_valid", evt_if.evt_valid, 1);
          chk("evt_hold_data", got, held);
        end
        if (evt_if.evt_valid && evt_if.evt_ready) begin
          n_evt++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL evt_unexpected: got chan %0d state %0d, expected no event",
                     got.chan, got.state);
          end else begin
            e = exp_q.pop_front();
            chk("evt_chan", got.chan, e.chan);
            chk("evt_state", got.state, e.state);
            $display("event chan=%0d state=%0d accepted", got.chan, got.state);
          end
        end
        hold = evt_if.evt_valid && !evt_if.evt_ready;
        held = got;
      end
    end
  end

  // Stimulus
  initial begin
    int  cyc;
    logic seen_done;
    evt_if.evt_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_status", status, 0);
    chk("rst_busy", busy, 0);
    chk("rst_evt_valid", evt_if.evt_valid, 0);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_status", status, 0);
    chk("idle_evt_valid", evt_if.evt_valid, 0);
    chk("idle_evt_chan", evt_if.evt_chan, 0);
    chk("idle_evt_state", evt_if.evt_state, 0);
    chk("idle_scan_done", scan_done, 0);
    chk("idle_busy", busy, 0);

    // Pass 1: in[2] active
    evt_if.evt_ready = 1'b1;
    tog2 = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.push_back(evt_t'{chan: 2'd2, state: 1'b1});
    enable = 1'b1;
    wait_busy(10);
    wait_done(100, cyc);
    chk("pass1_done_latency", cyc, 36);
    chk("pass1_status", status, 4'b0100);
    tog2 = 1'b0;
    @(negedge clk);
    chk("scan_done_width", scan_done, 0);
    chk("pass1_evt_count", n_evt, 1);

    // Pass 2: in[2] static -> status[2] falls
    exp_q.push_back(evt_t'{chan: 2'd2, state: 1'b0});
    wait_done(100, cyc);
    chk("pass2_status", status, 0);
    // Pass 3: nothing changes
    wait_done(100, cyc);
    chk("pass3_done_latency", cyc, 36);
    chk("pass3_status", status, 0);
    chk("pass3_evt_count", n_evt, 2);
    chk("pass3_queue_empty", exp_q.size(), 0);

    // Pass 4: backpressure while ch0 and ch1 go active
    evt_if.evt_ready = 1'b0;
    tog_fast = 4'b0011;
    repeat (20) @(negedge clk);
    tog_fast = '0;
    seen_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (scan_done) seen_done = 1'b1;
    end
    chk("stall_no_scan_done", seen_done, 0);
    chk("stall_state", dut.state_q, WAIT_EVT);
    chk("stall_sel", dut.sel_q, 1);
    chk("stall_evt_valid", evt_if.evt_valid, 1);
    chk("stall_evt_chan", evt_if.evt_chan, 0);
    chk("stall_evt_state", evt_if.evt_state, 1);
    chk("stall_busy", busy, 1);
    exp_q.push_back(evt_t'{chan: 2'd0, state: 1'b1});
    exp_q.push_back(evt_t'{chan: 2'd1, state: 1'b1});
    evt_if.evt_ready = 1'b1;
    wait_done(100, cyc);
    chk("pass4_release_to_done", cyc, 19);
    chk("pass4_status", status, 4'b0011);

    // Pass 5: ch0 and ch1 return idle
    exp_q.push_back(evt_t'{chan: 2'd0, state: 1'b0});
    exp_q.push_back(evt_t'{chan: 2'd1, state: 1'b0});
    wait_done(100, cyc);
    chk("pass5_done_latency", cyc, 36);
    chk("pass5_status", status, 0);

    // Pass 6: enable dropped mid-window of ch1
    exp_q.push_back(evt_t'{chan: 2'd1, state: 1'b1});
    tog_fast = 4'b0010;
    repeat (12) @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("stop_busy_in_update", busy, 1);
    @(negedge clk);
    chk("stop_busy_after", busy, 0);
    chk("stop_status", status, 4'b0010);
    chk("stop_state", dut.state_q, IDLE);
    chk("stop_sel", dut.sel_q, 0);
    tog_fast = '0;
    repeat (5) @(negedge clk);
    chk("stop_evt_count", n_evt, 7);
    chk("stop_queue_empty", exp_q.size(), 0);

    // Reset during WAIT_EVT
    evt_if.evt_ready = 1'b0;
    tog_fast = 4'b0001;
    enable = 1'b1;
    wait_wait_evt(100);
    chk("rstw_sel", dut.sel_q, 1);
    chk("rstw_status", status, 4'b0001);
    chk("rstw_evt_chan", evt_if.evt_chan, 0);
    chk("rstw_evt_valid", evt_if.evt_valid, 1);
    #2;
    resetn = 1'b0;
    tog_fast = '0;
    enable = 1'b0;
    #1;
    chk("rstw_async_evt_valid", evt_if.evt_valid, 0);
    chk("rstw_async_status", status, 0);
    chk("rstw_async_busy", busy, 0);
    @(negedge clk);
    chk("rstw_state", dut.state_q, IDLE);
    #2;
    resetn = 1'b1;
    evt_if.evt_ready = 1'b1;
    repeat (6) @(negedge clk);
    enable = 1'b1;
    wait_busy(10);
    chk("rescan_sel", dut.sel_q, 0);
    wait_done(100, cyc);
    chk("rescan_done_latency", cyc, 36);
    chk("rescan_status", status, 0);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("final_evt_count", n_evt, 7);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
